// File: rtl/rover_drive_ctrl.sv
// N-channel H-bridge drive: PWM, slew ramp, dead-time reversal, fault retry.
// Optional RDC_BRAKE_EN: dynamic brake (h_in = 11) when idle or faulted.
module rover_drive_ctrl #(
  parameter int CH           = 2,
  parameter int SPEED_W      = 3,
  parameter int PWM_W        = 8,
  parameter int RAMP_DIV     = 1024,
  parameter int DEADTIME     = 256,
  parameter int RETRY_CYCLES = 65536,
  parameter int MAX_RETRY    = 3
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [CH*SPEED_W-1:0] cmd_speed,
  input  logic [CH-1:0]         cmd_dir,
  input  logic                  cmd_valid,
  input  logic [CH-1:0]         sens,
  input  logic                  fault_clear,
  output logic [CH-1:0]         pwm_en,
  output logic [2*CH-1:0]       h_in,
  output logic [CH*SPEED_W-1:0] cur_speed,
  output logic [CH-1:0]         fault,
  output logic [CH-1:0]         latched
);

  localparam int RW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int DW = (DEADTIME > 0) ? $clog2(DEADTIME + 1) : 1;
  localparam int TW = (RETRY_CYCLES > 0) ? $clog2(RETRY_CYCLES + 1) : 1;
  localparam int FW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [SPEED_W-1:0] FULL = '1;

  typedef enum logic [1:0] {RUN, DEAD, FAULT, LATCH} state_t;

  logic [PWM_W-1:0] pwm_cnt;
  logic [PWM_W-1:0] pwm_nx;
  logic [RW-1:0]    ramp_cnt;
  logic             tick;

  assign pwm_nx = pwm_cnt + PWM_W'(1);
  assign tick   = (ramp_cnt == RW'(RAMP_DIV - 1));

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pwm_cnt  <= '0;
      ramp_cnt <= '0;
    end else begin
      pwm_cnt  <= pwm_nx;
      ramp_cnt <= tick ? '0 : ramp_cnt + RW'(1);
    end
  end

  for (genvar k = 0; k < CH; k++) begin : g_ch
    state_t             st, st_nx;
    logic [SPEED_W-1:0] spd, spd_nx, tspd;
    logic               dir, dir_nx, tdir;
    logic [DW-1:0]      dcnt, dcnt_nx;
    logic [TW-1:0]      rcnt, rcnt_nx;
    logic [FW-1:0]      fcnt, fcnt_nx, fbase, finc;
    logic               s1, s2;
    logic [PWM_W-1:0]   duty;
    logic               pwm_d, pwm_q;
    logic [1:0]         h_d, h_q;
    logic               flt_q, lat_q;

    always_comb begin
      st_nx   = st;
      spd_nx  = spd;
      dir_nx  = dir;
      dcnt_nx = dcnt;
      rcnt_nx = rcnt;
      fbase   = fault_clear ? '0 : fcnt;
      finc    = (fbase == FW'(MAX_RETRY)) ? fbase : fbase + FW'(1);
      fcnt_nx = fbase;
      unique case (st)
        RUN, DEAD: begin
          if (s2) begin
            spd_nx  = '0;
            fcnt_nx = finc;
            if (finc == FW'(MAX_RETRY)) begin
              st_nx = LATCH;
            end else begin
              st_nx   = FAULT;
              rcnt_nx = TW'(RETRY_CYCLES);
            end
          end else if (st == DEAD) begin
            if (dcnt <= DW'(1)) begin
              dir_nx = tdir;
              st_nx  = RUN;
            end else begin
              dcnt_nx = dcnt - DW'(1);
            end
          end else if (tdir != dir) begin
            // coast down to zero before the bridge may reverse
            if (spd == '0) begin
              st_nx   = DEAD;
              dcnt_nx = DW'(DEADTIME);
            end else if (tick) begin
              spd_nx = spd - SPEED_W'(1);
            end
          end else if (tick) begin
            if (tspd > spd) spd_nx = spd + SPEED_W'(1);
            else if (tspd < spd) spd_nx = spd - SPEED_W'(1);
          end
        end
        FAULT: begin
          if (rcnt <= TW'(1)) begin
            if (s2) begin
              rcnt_nx = TW'(RETRY_CYCLES);
            end else begin
              st_nx  = RUN;
              dir_nx = tdir;
            end
          end else begin
            rcnt_nx = rcnt - TW'(1);
          end
        end
        LATCH: begin
          if (fault_clear) begin
            st_nx  = RUN;
            dir_nx = tdir;
          end
        end
        default: st_nx = RUN;
      endcase
    end

    always_comb begin
      duty  = PWM_W'(spd_nx) << (PWM_W - SPEED_W);
      pwm_d = 1'b0;
      h_d   = 2'b00;
      if (st_nx == RUN) begin
        if (spd_nx != '0) begin
          pwm_d = (spd_nx == FULL) || (pwm_nx < duty);
          h_d   = dir_nx ? 2'b01 : 2'b10;
        end
`ifdef RDC_BRAKE_EN
        else begin
          pwm_d = 1'b1;
          h_d   = 2'b11;
        end
`endif
      end
`ifdef RDC_BRAKE_EN
      if (st_nx == FAULT || st_nx == LATCH) h_d = 2'b11;
`endif
    end

    always_ff @(posedge clock) begin
      if (!reset_n) begin
        st    <= RUN;
        spd   <= '0;
        dir   <= 1'b1;
        tspd  <= '0;
        tdir  <= 1'b1;
        dcnt  <= '0;
        rcnt  <= '0;
        fcnt  <= '0;
        s1    <= 1'b0;
        s2    <= 1'b0;
        pwm_q <= 1'b0;
        h_q   <= 2'b00;
        flt_q <= 1'b0;
        lat_q <= 1'b0;
      end else begin
        st    <= st_nx;
        spd   <= spd_nx;
        dir   <= dir_nx;
        dcnt  <= dcnt_nx;
        rcnt  <= rcnt_nx;
        fcnt  <= fcnt_nx;
        s1    <= sens[k];
        s2    <= s1;
        pwm_q <= pwm_d;
        h_q   <= h_d;
        flt_q <= (st_nx == FAULT) || (st_nx == LATCH);
        lat_q <= (st_nx == LATCH);
        if (cmd_valid) begin
          tspd <= cmd_speed[k*SPEED_W +: SPEED_W];
          tdir <= cmd_dir[k];
        end
      end
    end

    assign pwm_en[k]                     = pwm_q;
    assign h_in[2*k +: 2]                = h_q;
    assign cur_speed[k*SPEED_W +: SPEED_W] = spd;
    assign fault[k]                      = flt_q;
    assign latched[k]                    = lat_q;
  end

endmodule

// File: tb/tb_rover_drive_ctrl.sv
// Bench for rover_drive_ctrl: directed scenarios plus random traffic
// checked every cycle against a rule-level reference model.
module tb_rover_drive_ctrl;
  localparam int CH = 2, SW = 3, PW = 4, RD = 4, DT = 8, RC = 16, MR = 3;
`ifdef RDC_BRAKE_EN
  localparam bit BRK = 1'b1;
`else
  localparam bit BRK = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic [CH*SW-1:0] cmd_speed = '0;
  logic [CH-1:0] cmd_dir = '0;
  logic cmd_valid = 1'b0;
  logic [CH-1:0] sens = '0;
  logic fault_clear = 1'b0;
  logic [CH-1:0] pwm_en;
  logic [2*CH-1:0] h_in;
  logic [CH*SW-1:0] cur_speed;
  logic [CH-1:0] fault;
  logic [CH-1:0] latched;

  int total = 0;
  int bad = 0;

  always #5 clock = ~clock;

  rover_drive_ctrl #(
    .CH(CH), .SPEED_W(SW), .PWM_W(PW), .RAMP_DIV(RD),
    .DEADTIME(DT), .RETRY_CYCLES(RC), .MAX_RETRY(MR)
  ) dut (
    .clock(clock), .reset_n(reset_n), .cmd_speed(cmd_speed),
    .cmd_dir(cmd_dir), .cmd_valid(cmd_valid), .sens(sens),
    .fault_clear(fault_clear), .pwm_en(pwm_en), .h_in(h_in),
    .cur_speed(cur_speed), .fault(fault), .latched(latched)
  );

  // model: 0 run, 1 dead, 2 fault, 3 latch
  int m_mode[CH], m_spd[CH], m_dir[CH], m_ts[CH], m_td[CH];
  int m_tm[CH], m_fc[CH], m_sh1[CH], m_sh2[CH];
  int m_n = 0;
  bit m_rst = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    bit tick;
    int base;
    if (!reset_n) begin
      for (int k = 0; k < CH; k++) begin
        m_mode[k] = 0; m_spd[k] = 0; m_dir[k] = 1;
        m_ts[k] = 0; m_td[k] = 1; m_tm[k] = 0; m_fc[k] = 0;
        m_sh1[k] = 0; m_sh2[k] = 0;
      end
      m_n = 0;
      m_rst = 1'b1;
    end else begin
      m_rst = 1'b0;
      tick = ((m_n % RD) == RD - 1);
      for (int k = 0; k < CH; k++) begin
        base = fault_clear ? 0 : m_fc[k];
        m_fc[k] = base;
        if (m_mode[k] <= 1 && m_sh2[k] != 0) begin
          m_fc[k] = (base < MR) ? base + 1 : MR;
          m_spd[k] = 0;
          if (m_fc[k] == MR) m_mode[k] = 3;
          else begin m_mode[k] = 2; m_tm[k] = RC; end
        end else if (m_mode[k] == 1) begin
          m_tm[k]--;
          if (m_tm[k] <= 0) begin m_dir[k] = m_td[k]; m_mode[k] = 0; end
        end else if (m_mode[k] == 2) begin
          m_tm[k]--;
          if (m_tm[k] <= 0) begin
            if (m_sh2[k] != 0) m_tm[k] = RC;
            else begin m_mode[k] = 0; m_dir[k] = m_td[k]; end
          end
        end else if (m_mode[k] == 3) begin
          if (fault_clear) begin m_mode[k] = 0; m_dir[k] = m_td[k]; end
        end else if (m_td[k] != m_dir[k]) begin
          if (m_spd[k] == 0) begin m_mode[k] = 1; m_tm[k] = DT; end
          else if (tick) m_spd[k]--;
        end else if (tick) begin
          if (m_ts[k] > m_spd[k]) m_spd[k]++;
          else if (m_ts[k] < m_spd[k]) m_spd[k]--;
        end
      end
      for (int k = 0; k < CH; k++) begin
        if (cmd_valid) begin
          m_ts[k] = int'(cmd_speed[k*SW +: SW]);
          m_td[k] = int'(cmd_dir[k]);
        end
        m_sh2[k] = m_sh1[k];
        m_sh1[k] = int'(sens[k]);
      end
      m_n++;
    end
  endtask

  task automatic compare_all();
    int eh, ep, d;
    for (int k = 0; k < CH; k++) begin
      eh = 0; ep = 0;
      if (!m_rst) begin
        if (m_mode[k] == 0) begin
          if (m_spd[k] == 0) begin
            eh = BRK ? 3 : 0; ep = BRK ? 1 : 0;
          end else begin
            eh = m_dir[k] ? 1 : 2;
            d = m_spd[k] * (1 << (PW - SW));
            ep = (m_spd[k] == (1 << SW) - 1 ||
                  (m_n % (1 << PW)) < d) ? 1 : 0;
          end
        end else if (m_mode[k] >= 2) begin
          eh = BRK ? 3 : 0;
        end
      end
      chk($sformatf("speed%0d@%0t", k, $time), cur_speed[k*SW +: SW], m_spd[k]);
      chk($sformatf("pwm%0d@%0t", k, $time), pwm_en[k], ep);
      chk($sformatf("h%0d@%0t", k, $time), h_in[2*k +: 2], eh);
      chk($sformatf("fault%0d@%0t", k, $time), fault[k], (m_mode[k] >= 2) ? 1 : 0);
      chk($sformatf("latch%0d@%0t", k, $time), latched[k], (m_mode[k] == 3) ? 1 : 0);
    end
  endtask

  task automatic cycle();
    @(posedge clock);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic send(input int s0, input int d0, input int s1, input int d1);
    cmd_speed = {SW'(s1), SW'(s0)};
    cmd_dir = {1'(d1), 1'(d0)};
    cmd_valid = 1'b1;
    cycle();
    cmd_valid = 1'b0;
  endtask

  initial begin
    int c, w;
    for (int k = 0; k < CH; k++) begin
      m_mode[k] = 0; m_spd[k] = 0; m_dir[k] = 1; m_ts[k] = 0; m_td[k] = 1;
      m_tm[k] = 0; m_fc[k] = 0; m_sh1[k] = 0; m_sh2[k] = 0;
    end
    #2;
    repeat (3) cycle();
    chk("rst_speed", cur_speed, 0);
    chk("rst_h", h_in, 0);
    chk("rst_pwm", pwm_en, 0);
    chk("rst_fault", {fault, latched}, 0);
    reset_n = 1'b1;
    cycle();
`ifdef RDC_BRAKE_EN
    chk("brake_idle_h", h_in[1:0], 3);
    chk("brake_idle_pwm", pwm_en[0], 1);
`endif

    send(7, 1, 0, 1);
    repeat (40) cycle();
    chk("full_speed", cur_speed[SW-1:0], 7);
    chk("full_h", h_in[1:0], 1);
    c = 0;
    repeat (16) begin cycle(); c += int'(pwm_en[0]); end
    chk("full_pwm", c, 16);

    send(4, 1, 0, 1);
    repeat (20) cycle();
    send(4, 0, 0, 1);
    c = 0;
    repeat (12) begin cycle(); end
    w = 0;
    while (h_in[1:0] != 2'b00 && w < 40) begin cycle(); w++; end
    repeat (4) begin cycle(); c += (h_in[1:0] == 2'b00) ? 1 : 0; end
    chk("dead_coast", c, 4);
    repeat (60) cycle();
    chk("rev_speed", cur_speed[SW-1:0], 4);
    chk("rev_h", h_in[1:0], 2);
    c = 0;
    repeat (16) begin cycle(); c += int'(pwm_en[0]); end
    chk("half_pwm", c, 8);

    send(4, 0, 5, 1);
    repeat (30) cycle();
    sens[1] = 1'b1;
    cycle();
    chk("sens_lat1", fault[1], 0);
    cycle();
    chk("sens_lat2", fault[1], 0);
    sens[1] = 1'b0;
    cycle();
    chk("sens_lat3", fault[1], 1);
`ifdef RDC_BRAKE_EN
    chk("brake_flt_h", h_in[3:2], 3);
    chk("brake_flt_pwm", pwm_en[1], 0);
`endif
    c = 1; w = 0;
    repeat (40) begin
      cycle(); c += int'(fault[1]); w += int'(fault[0]);
    end
    chk("fault_len", c, 16);
    chk("ch0_indep", w, 0);
    chk("ch1_recover", cur_speed[2*SW-1:SW], 5);

    for (int i = 0; i < 3; i++) begin
      sens[0] = 1'b1;
      cycle(); cycle();
      sens[0] = 1'b0;
      repeat (28) cycle();
    end
    c = 0;
    repeat (200) begin cycle(); c += int'(latched[0]); end
    chk("latch_hold", c, 200);
    fault_clear = 1'b1;
    cycle();
    fault_clear = 1'b0;
    chk("clear_latch", latched[0], 0);
    repeat (40) cycle();
    chk("clear_ramp", cur_speed[SW-1:0], 4);

    send(6, 1, 5, 1);
    w = 0;
    while (!(cur_speed[SW-1:0] == 3'd3 && h_in[1:0] == 2'b01) && w < 300) begin
      cycle(); w++;
    end
    chk("reach3", (w < 300) ? 1 : 0, 1);
    reset_n = 1'b0;
    cycle();
    reset_n = 1'b1;
    chk("mid_rst_speed", cur_speed, 0);
    chk("mid_rst_out", {pwm_en, h_in, fault, latched}, 0);
    c = 0;
    repeat (30) begin cycle(); c += (cur_speed[SW-1:0] != 0) ? 1 : 0; end
    chk("stay_zero", c, 0);

    repeat (1500) begin
      cmd_valid = ($urandom_range(0, 15) == 0);
      cmd_speed = CH*SW'($urandom);
      cmd_dir = CH'($urandom);
      for (int k = 0; k < CH; k++) begin
        if (sens[k]) sens[k] = ($urandom_range(0, 2) != 0);
        else sens[k] = ($urandom_range(0, 59) == 0);
      end
      fault_clear = ($urandom_range(0, 99) == 0);
      reset_n = ($urandom_range(0, 499) != 0);
      cycle();
    end
    cmd_valid = 1'b0;
    fault_clear = 1'b0;
    reset_n = 1'b1;
    sens = '0;
    repeat (5) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rover_drive_ctrl.md
# rover_drive_ctrl

Parametrised N-channel H-bridge drive controller for the delivery rover. It replaces the fixed two-motor PWM, current-limit and motor-driver path with one block per drive train. Each channel has:
- a PWM generator;
- slew-rate speed ramping;
- dead-time-protected direction reversal;
- overcurrent handling with timed auto-retry and a latching fault after repeated trips.

It sits between the switch/command decode logic and the motor driver pins.

## Interface
Parameters:
- CH, 2: number of motor channels
- SPEED_W, 3: speed command width; must be ≤ PWM_W
- PWM_W, 8: PWM counter width; PWM period is 2^PWM_W clocks
- RAMP_DIV, 1024: clocks per ramp tick; must be ≥ 1
- DEADTIME, 256: clocks both bridge inputs are held low on reversal
- RETRY_CYCLES, 65536: fault cool-down length in clocks
- MAX_RETRY, 3: fault count at which a channel latches

Ports:
- clock  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- cmd_speed  in  CH*SPEED_W  target speed per channel; channel k is in bits [k*SPEED_W +: SPEED_W]
- cmd_dir  in  CH  target direction per channel; 1 = forward
- cmd_valid  in  1  single-cycle strobe that captures cmd_speed and cmd_dir for all channels
- sens  in  CH  asynchronous overcurrent flags, active high
- fault_clear  in  1  single-cycle strobe that clears latched faults and fault counts
- pwm_en  out  CH  bridge enable (PWM)
- h_in  out  2*CH  bridge inputs; channel k is {h_in[2k+1], h_in[2k]}
- cur_speed  out  CH*SPEED_W  current ramped speed
- fault  out  CH  high while a channel is in FAULT or LATCH
- latched  out  CH  high while a channel is in LATCH

## Operation
- **Reset:** while reset_n is low at a clock edge, the following clear:
  - Outputs: pwm_en = 0, h_in = 0, cur_speed = 0, fault = 0, latched = 0.
  - Internal: targets = 0 with direction = 1; cur_dir = 1; all counters = 0; fault counts = 0; every channel in RUN.
- **Command capture:** a cmd_valid pulse registers the targets for all channels. Targets hold until the next cmd_valid.
- **Shared counters:**
  - The PWM counter free-runs 0..2^PWM_W−1 and wraps.
  - The ramp tick fires once every RAMP_DIV clocks.
- **Sensor synchroniser:** sens passes through a 2-flop synchroniser per channel.
- **Channel FSM, RUN:**
  - On a ramp tick with target direction == cur_dir: cur_speed steps ±1 toward the target speed.
  - On a ramp tick with target direction ≠ cur_dir and cur_speed > 0: cur_speed steps −1.
  - If target direction ≠ cur_dir and cur_speed == 0: go to DEAD.
- **Channel FSM, DEAD:**
  - pwm_en = 0 and h_in = 00 for DEADTIME clocks.
  - Then cur_dir takes the target direction and the channel returns to RUN.
- **Channel FSM, FAULT:**
  - Entered from RUN or DEAD when the synchronised sens is 1.
  - On entry: cur_speed = 0, fault count +1, cool-down counter loaded with RETRY_CYCLES.
  - If the incremented count == MAX_RETRY, go to LATCH instead.
  - When the counter reaches 0: if sens is still high, reload the counter and stay. Otherwise take cur_dir from the target and go to RUN, ramping up from 0.
- **Channel FSM, LATCH:**
  - Held indefinitely. fault_clear moves the channel to RUN with fault count = 0.
  - fault_clear in any other state only zeroes the fault count.
- **Duty cycle:**
  - duty = cur_speed << (PWM_W − SPEED_W).
  - pwm_en = (pwm_cnt < duty), except that all-ones cur_speed gives constant 1 and 0 gives constant 0.
  - pwm_en is forced to 0 outside RUN.
- **Bridge drive:**
  - In RUN with cur_speed > 0: h_in = 01 for forward, 10 for reverse.
  - Idle (RUN with cur_speed = 0), FAULT and LATCH: h_in = 00 (coast).
- **Simultaneous events:**
  - sens taking priority over a ramp step or a DEAD transition: fault wins.
  - cmd_valid in the same cycle as a fault: the target is still captured.
  - Fault count saturates at MAX_RETRY.
- **Independence:** channels are fully independent apart from the shared counters.

## Timing
- All outputs are registered.
- cmd_valid at edge t: the new target is visible at t+1. The first speed change happens on the next ramp tick.
- Ramp slew: one LSB per RAMP_DIV clocks. A full-scale reversal takes 2·(2^SPEED_W−1)·RAMP_DIV + DEADTIME clocks, plus up to RAMP_DIV clocks of tick phase.
- sens rising and stable before edge t: FAULT is entered, and pwm_en = 0, h_in = 00, cur_speed = 0 are visible, after edge t+2. Latency is 3 edges.
- A FAULT lasts exactly RETRY_CYCLES clocks when sens has already cleared.
- A reset_n assertion mid-ramp, mid-DEAD or mid-FAULT restores the full reset state on the next edge.

## Configuration
- RDC_BRAKE_EN defined: idle, FAULT and LATCH drive h_in = 11 (dynamic brake), with pwm_en = 1 in idle only. FAULT and LATCH keep pwm_en = 0. DEAD still drives 00.
- RDC_BRAKE_EN undefined: coast (h_in = 00, pwm_en = 0) in all those states.

## Test plan
Parameters for all scenarios: CH=2, SPEED_W=3, PWM_W=4, RAMP_DIV=4, DEADTIME=8, RETRY_CYCLES=16, MAX_RETRY=3.
- Reset, then cmd_speed ch0=7, dir=1, one cmd_valid → cur_speed ch0 steps 1..7, one step every 4 clocks. Afterwards pwm_en ch0 is constant 1 and h_in ch0 = 01.
- Ch0 at speed 4, then a command with dir=0, speed=4 → ramps 4→0, holds h_in = 00 for 8 clocks, then ramps 0→4 with h_in = 10. pwm_en is high for 8 of every 16 clocks at speed 4.
- Ch1 running, sens[1] pulsed for 2 clocks → fault[1] rises 3 edges later. It clears after 16 clocks and ch1 ramps back toward its target. Ch0 is unaffected.
- Three sens[0] pulses spaced 30 clocks apart → latched[0] = 1 after the third. It stays 1 for 200 clocks. fault_clear returns ch0 to RUN and it ramps up.
- Command ramping to speed 6 and reset_n pulled low for 1 clock at speed 3 → all outputs are 0 on the next edge and ch0 stays at 0 with no new cmd_valid.
- Build with RDC_BRAKE_EN, speed 0 → h_in ch0 = 11 and pwm_en = 1. During a fault → h_in = 11 and pwm_en = 0.
